// File: rtl/fifo_stage_arbiter_if.sv
// Handshake bundle between the UART RX writer, UART TX reader, the attached
// FIFO and the stage arbiter that serialises their access.
interface fifo_stage_arbiter_if #(
  parameter int fifo_bit_len = 8
);
  logic                    wr_req;
  logic [fifo_bit_len-1:0] wr_data;
  logic                    wr_ack;
  logic                    rd_req;
  logic                    rd_ack;
  logic [fifo_bit_len-1:0] rd_data;
  logic [1:0]              fifo_stage;
  logic [fifo_bit_len-1:0] fifo_din;
  logic [fifo_bit_len-1:0] fifo_dout;
  logic [3:0]              level;
  logic                    full;
  logic                    empty;

  // The arbiter is the slave; the master side is the requesters plus the FIFO.
  modport slave (
    input  wr_req, wr_data, rd_req, fifo_dout,
    output wr_ack, rd_ack, rd_data, fifo_stage, fifo_din, level, full, empty
  );

  modport master (
    output wr_req, wr_data, rd_req, fifo_dout,
    input  wr_ack, rd_ack, rd_data, fifo_stage, fifo_din, level, full, empty
  );
endinterface

// File: rtl/fifo_stage_arbiter.sv
// Round-robin arbiter that sequences writer and reader access to a single-port
// FIFO, keeping a shadow occupancy count so neither side over/underflows it.
module fifo_stage_arbiter #(
  parameter int fifo_size    = 6,
  parameter int fifo_bit_len = 8
) (
  input  logic                 slow_clk,
  input  logic                 nreset,
  fifo_stage_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_CAP} state_t;
  typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

  localparam logic [1:0] STAGE_IDLE = 2'b00;
  localparam logic [1:0] STAGE_RD   = 2'b01;
  localparam logic [1:0] STAGE_WR   = 2'b10;
  localparam logic [3:0] FULL_LEVEL = 4'(fifo_size);

  state_t                  state, state_nxt;
  grant_t                  last_grant, last_grant_nxt;
  logic [1:0]              fifo_stage_q, fifo_stage_nxt;
  logic [fifo_bit_len-1:0] fifo_din_q, fifo_din_nxt;
  logic [fifo_bit_len-1:0] rd_data_q, rd_data_nxt;
  logic                    wr_ack_q, wr_ack_nxt;
  logic                    rd_ack_q, rd_ack_nxt;
  logic [3:0]              level_q, level_nxt;

  logic wr_elig, rd_elig, grant_wr, grant_rd;

  assign wr_elig  = bus.wr_req && (level_q < FULL_LEVEL);
  assign rd_elig  = bus.rd_req && (level_q != 4'd0);
  // On a tie the side that did not win last time goes first.
  assign grant_wr = wr_elig && (!rd_elig || (last_grant == GRANT_RD));
  assign grant_rd = rd_elig && !grant_wr;

  always_ff @(posedge slow_clk) begin
    if (nreset) begin
      state        <= IDLE;
      last_grant   <= GRANT_RD;
      fifo_stage_q <= STAGE_IDLE;
      fifo_din_q   <= '0;
      rd_data_q    <= '0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      level_q      <= 4'd0;
    end else begin
      state        <= state_nxt;
      last_grant   <= last_grant_nxt;
      fifo_stage_q <= fifo_stage_nxt;
      fifo_din_q   <= fifo_din_nxt;
      rd_data_q    <= rd_data_nxt;
      wr_ack_q     <= wr_ack_nxt;
      rd_ack_q     <= rd_ack_nxt;
      level_q      <= level_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    fifo_stage_nxt = STAGE_IDLE;
    fifo_din_nxt   = fifo_din_q;
    rd_data_nxt    = rd_data_q;
    wr_ack_nxt     = 1'b0;
    rd_ack_nxt     = 1'b0;
    level_nxt      = level_q;
    case (state)
      IDLE: begin
        if (grant_wr) begin
          state_nxt      = WR;
          fifo_stage_nxt = STAGE_WR;
          fifo_din_nxt   = bus.wr_data;
          wr_ack_nxt     = 1'b1;
          level_nxt      = level_q + 4'd1;
          last_grant_nxt = GRANT_WR;
        end else if (grant_rd) begin
          state_nxt      = RD;
          fifo_stage_nxt = STAGE_RD;
          level_nxt      = level_q - 4'd1;
          last_grant_nxt = GRANT_RD;
        end
      end
      WR:     state_nxt = IDLE;
      RD:     state_nxt = RD_CAP;
      // The FIFO presents the popped word one cycle after the Reading command.
      RD_CAP: begin
        rd_data_nxt = bus.fifo_dout;
        rd_ack_nxt  = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.fifo_stage = fifo_stage_q;
  assign bus.fifo_din   = fifo_din_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.level      = level_q;
  assign bus.full       = (level_q == FULL_LEVEL);
  assign bus.empty      = (level_q == 4'd0);

endmodule

// File: tb/tb_fifo_stage_arbiter.sv
// Directed bench for fifo_stage_arbiter with a behavioural model of the
// attached FIFO answering the Reading/Writing commands.
module tb_fifo_stage_arbiter;

  logic slow_clk = 1'b0;
  logic nreset   = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  fifo_stage_arbiter_if #(.fifo_bit_len(8)) bus ();

  fifo_stage_arbiter #(.fifo_size(6), .fifo_bit_len(8)) dut (
    .slow_clk (slow_clk),
    .nreset   (nreset),
    .bus      (bus)
  );

  always #5 slow_clk = ~slow_clk;

  // Attached FIFO: stores on Writing, presents the head one edge after Reading.
  logic [7:0] fifo_q[$];
  always @(posedge slow_clk) begin
    if (nreset) begin
      fifo_q.delete();
      bus.fifo_dout <= 8'h00;
    end else if (bus.fifo_stage == 2'b10) begin
      fifo_q.push_back(bus.fifo_din);
    end else if (bus.fifo_stage == 2'b01 && fifo_q.size() > 0) begin
      bus.fifo_dout <= fifo_q.pop_front();
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] data, output bit acked);
    acked = 1'b0;
    bus.wr_data = data;
    bus.wr_req  = 1'b1;
    for (int i = 0; i < 20 && !acked; i++) begin
      tick();
      if (bus.wr_ack === 1'b1) acked = 1'b1;
    end
    bus.wr_req = 1'b0;
    tick();
  endtask

  task automatic do_read(output logic [7:0] data, output bit acked);
    acked = 1'b0;
    data  = 8'h00;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 20 && !acked; i++) begin
      tick();
      if (bus.rd_ack === 1'b1) begin
        acked = 1'b1;
        data  = bus.rd_data;
      end
    end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    tick();
    tick();
    vectors++; if (bus.fifo_stage !== 2'b00) begin miscompares++; $display("[TB] FAIL reset fifo_stage: got %b expected 00", bus.fifo_stage); end
    vectors++; if (bus.fifo_din !== 8'h00) begin miscompares++; $display("[TB] FAIL reset fifo_din: got %h expected 00", bus.fifo_din); end
    vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset rd_data: got %h expected 00", bus.rd_data); end
    vectors++; if (bus.wr_ack !== 1'b0 || bus.rd_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset acks: got wr %b rd %b expected 0 0", bus.wr_ack, bus.rd_ack); end
    vectors++; if (bus.level !== 4'd0) begin miscompares++; $display("[TB] FAIL reset level: got %0d expected 0", bus.level); end
    vectors++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset flags: got empty %b full %b expected 1 0", bus.empty, bus.full); end
    nreset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    bus.wr_data = 8'hA5;
    bus.wr_req  = 1'b1;
    tick();
    vectors++; if (bus.fifo_stage !== 2'b10) begin miscompares++; $display("[TB] FAIL wr grant stage: got %b expected 10", bus.fifo_stage); end
    vectors++; if (bus.fifo_din !== 8'hA5) begin miscompares++; $display("[TB] FAIL wr fifo_din: got %h expected a5", bus.fifo_din); end
    vectors++; if (bus.wr_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_ack pulse: got %b expected 1", bus.wr_ack); end
    vectors++; if (bus.level !== 4'd1 || bus.empty !== 1'b0) begin miscompares++; $display("[TB] FAIL wr level: got %0d empty %b expected 1 0", bus.level, bus.empty); end
    bus.wr_req = 1'b0;
    tick();
    vectors++; if (bus.fifo_stage !== 2'b00 || bus.wr_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL wr end: got stage %b ack %b expected 00 0", bus.fifo_stage, bus.wr_ack); end
    vectors++; if (bus.fifo_din !== 8'hA5) begin miscompares++; $display("[TB] FAIL fifo_din hold: got %h expected a5", bus.fifo_din); end
    bus.rd_req = 1'b1;
    tick();
    vectors++; if (bus.fifo_stage !== 2'b01 || bus.rd_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL rd grant: got stage %b ack %b expected 01 0", bus.fifo_stage, bus.rd_ack); end
    vectors++; if (bus.level !== 4'd0 || bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rd level: got %0d empty %b expected 0 1", bus.level, bus.empty); end
    tick();
    vectors++; if (bus.fifo_stage !== 2'b00 || bus.rd_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL rd cap: got stage %b ack %b expected 00 0", bus.fifo_stage, bus.rd_ack); end
    tick();
    vectors++; if (bus.rd_ack !== 1'b1 || bus.rd_data !== 8'hA5) begin miscompares++; $display("[TB] FAIL rd ack: got ack %b data %h expected 1 a5", bus.rd_ack, bus.rd_data); end
    bus.rd_req = 1'b0;
    tick();
    vectors++; if (bus.rd_ack !== 1'b0 || bus.rd_data !== 8'hA5) begin miscompares++; $display("[TB] FAIL rd hold: got ack %b data %h expected 0 a5", bus.rd_ack, bus.rd_data); end
  endtask

  task automatic test_full();
    bit         ok, seen, rd_seen, wr_seen, wr_after_rd;
    logic [7:0] d, rd_val;
    for (int i = 1; i <= 6; i++) begin
      do_write(8'(i), ok);
      vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL fill write %0d: got no ack expected ack", i); end
    end
    vectors++; if (bus.level !== 4'd6 || bus.full !== 1'b1) begin miscompares++; $display("[TB] FAIL full flag: got level %0d full %b expected 6 1", bus.level, bus.full); end
    bus.wr_data = 8'h07;
    bus.wr_req  = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (bus.wr_ack === 1'b1 || bus.fifo_stage !== 2'b00) seen = 1'b1;
    end
    vectors++; if (seen || bus.level !== 4'd6) begin miscompares++; $display("[TB] FAIL write while full: got activity %b level %0d expected 0 6", seen, bus.level); end
    bus.rd_req = 1'b1;
    rd_seen = 1'b0; wr_seen = 1'b0; wr_after_rd = 1'b0; rd_val = 8'h00;
    for (int i = 0; i < 20 && !wr_seen; i++) begin
      tick();
      if (bus.rd_ack === 1'b1) begin rd_seen = 1'b1; rd_val = bus.rd_data; bus.rd_req = 1'b0; end
      if (bus.wr_ack === 1'b1) begin wr_seen = 1'b1; wr_after_rd = rd_seen; bus.wr_req = 1'b0; end
    end
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    vectors++; if (!rd_seen || rd_val !== 8'h01) begin miscompares++; $display("[TB] FAIL read from full: got ack %b data %h expected 1 01", rd_seen, rd_val); end
    vectors++; if (!wr_seen || !wr_after_rd) begin miscompares++; $display("[TB] FAIL pending write: got ack %b after_read %b expected 1 1", wr_seen, wr_after_rd); end
    tick();
    vectors++; if (bus.level !== 4'd6 || bus.full !== 1'b1) begin miscompares++; $display("[TB] FAIL refill level: got %0d full %b expected 6 1", bus.level, bus.full); end
    for (int i = 2; i <= 7; i++) begin
      do_read(d, ok);
      vectors++; if (!ok || d !== 8'(i)) begin miscompares++; $display("[TB] FAIL drain %0d: got ack %b data %h expected 1 %h", i, ok, d, 8'(i)); end
    end
    tick();
    vectors++; if (bus.level !== 4'd0 || bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL drained: got level %0d empty %b expected 0 1", bus.level, bus.empty); end
  endtask

  task automatic test_read_empty();
    int         bad;
    bit         rd_seen, wr_seen, wr_first;
    logic [7:0] rd_val;
    bad = 0;
    bus.rd_req = 1'b1;
    repeat (5) begin
      tick();
      if (bus.rd_ack !== 1'b0 || bus.fifo_stage !== 2'b00) bad++;
    end
    vectors++; if (bad != 0 || bus.level !== 4'd0) begin miscompares++; $display("[TB] FAIL read while empty: got %0d active cycles level %0d expected 0 0", bad, bus.level); end
    bus.wr_data = 8'h3C;
    bus.wr_req  = 1'b1;
    rd_seen = 1'b0; wr_seen = 1'b0; wr_first = 1'b0; rd_val = 8'h00;
    for (int i = 0; i < 20 && !rd_seen; i++) begin
      tick();
      if (bus.wr_ack === 1'b1) begin wr_seen = 1'b1; wr_first = !rd_seen; bus.wr_req = 1'b0; end
      if (bus.rd_ack === 1'b1) begin rd_seen = 1'b1; rd_val = bus.rd_data; bus.rd_req = 1'b0; end
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    vectors++; if (!wr_seen || !wr_first) begin miscompares++; $display("[TB] FAIL empty wakeup write: got ack %b first %b expected 1 1", wr_seen, wr_first); end
    vectors++; if (!rd_seen || rd_val !== 8'h3C) begin miscompares++; $display("[TB] FAIL empty wakeup read: got ack %b data %h expected 1 3c", rd_seen, rd_val); end
    tick();
    vectors++; if (bus.level !== 4'd0 || bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL empty wakeup level: got %0d empty %b expected 0 1", bus.level, bus.empty); end
  endtask

  task automatic test_round_robin();
    bit         ok, done;
    logic [7:0] d;
    logic [3:0] seq;
    int         n, bad11, lvl_bad;
    for (int i = 0; i < 4; i++) do_write(8'h10 + 8'(i), ok);
    do_read(d, ok);
    tick();
    vectors++; if (!ok || d !== 8'h10 || bus.level !== 4'd3) begin miscompares++; $display("[TB] FAIL rr setup: got data %h level %0d expected 10 3", d, bus.level); end
    seq = 4'b0000; n = 0; bad11 = 0; lvl_bad = 0;
    bus.wr_data = 8'h20;
    bus.wr_req  = 1'b1;
    bus.rd_req  = 1'b1;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (bus.fifo_stage === 2'b11) bad11++;
      if (bus.fifo_stage === 2'b10) begin
        seq[n] = 1'b1; n++;
        if (bus.level !== 4'd4) lvl_bad++;
      end else if (bus.fifo_stage === 2'b01) begin
        seq[n] = 1'b0; n++;
        if (bus.level !== 4'd3) lvl_bad++;
      end
    end
    done = 1'b0; d = 8'h00;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (bus.fifo_stage === 2'b11) bad11++;
      if (bus.rd_ack === 1'b1) begin done = 1'b1; d = bus.rd_data; end
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    vectors++; if (n != 4 || seq !== 4'b0101) begin miscompares++; $display("[TB] FAIL rr order: got %0d grants seq %b expected 4 0101", n, seq); end
    vectors++; if (lvl_bad != 0) begin miscompares++; $display("[TB] FAIL rr level: got %0d bad levels expected 0", lvl_bad); end
    vectors++; if (bad11 != 0) begin miscompares++; $display("[TB] FAIL rr stage 11: got %0d cycles expected 0", bad11); end
    vectors++; if (!done || d !== 8'h12) begin miscompares++; $display("[TB] FAIL rr last read: got ack %b data %h expected 1 12", done, d); end
    tick();
    vectors++; if (bus.level !== 4'd3 || bus.fifo_stage !== 2'b00) begin miscompares++; $display("[TB] FAIL rr end: got level %0d stage %b expected 3 00", bus.level, bus.fifo_stage); end
  endtask

  task automatic test_reset_during_rd();
    bit         seen, ok;
    logic [7:0] d;
    bus.rd_req = 1'b1;
    tick();
    vectors++; if (bus.fifo_stage !== 2'b01 || bus.level !== 4'd2) begin miscompares++; $display("[TB] FAIL abort setup: got stage %b level %0d expected 01 2", bus.fifo_stage, bus.level); end
    nreset = 1'b1;
    bus.rd_req = 1'b0;
    tick();
    nreset = 1'b0;
    vectors++; if (bus.fifo_stage !== 2'b00 || bus.level !== 4'd0 || bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL abort state: got stage %b level %0d empty %b expected 00 0 1", bus.fifo_stage, bus.level, bus.empty); end
    seen = (bus.rd_ack === 1'b1);
    repeat (4) begin
      tick();
      if (bus.rd_ack === 1'b1) seen = 1'b1;
    end
    vectors++; if (seen) begin miscompares++; $display("[TB] FAIL abort ack: got rd_ack expected none"); end
    do_write(8'h55, ok);
    do_read(d, ok);
    vectors++; if (!ok || d !== 8'h55) begin miscompares++; $display("[TB] FAIL after abort: got ack %b data %h expected 1 55", ok, d); end
  endtask

  initial begin
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_data = 8'h00;
    test_reset();
    test_write_read();
    test_full();
    test_read_empty();
    test_round_robin();
    test_reset_during_rd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_stage_arbiter.md
FIFO_STAGE_ARBITER -- requirements
Module: fifo_stage_arbiter

Interface
REQ-001 SHALL have parameter fifo_size, default 6, meaning FIFO depth in words (matches attached FIFO).
REQ-002 SHALL have parameter fifo_bit_len, default 8, meaning data word width.
REQ-003 SHALL have port slow_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port nreset  input  1  reset, synchronous, active-high (1 = reset).
REQ-005 SHALL have port wr_req  input  1  writer (UART RX) request, held high until wr_ack.
REQ-006 SHALL have port wr_data  input  fifo_bit_len  write word, stable while wr_req high.
REQ-007 SHALL have port wr_ack  output  1  one-cycle pulse: write accepted.
REQ-008 SHALL have port rd_req  input  1  reader (UART TX) request, held high until rd_ack.
REQ-009 SHALL have port rd_ack  output  1  one-cycle pulse: rd_data valid.
REQ-010 SHALL have port rd_data  output  fifo_bit_len  registered read word.
REQ-011 SHALL have port fifo_stage  output  2  FIFO command: 00 Idle, 01 Reading, 10 Writing.
REQ-012 SHALL have port fifo_din  output  fifo_bit_len  word driven to FIFO Value_in.
REQ-013 SHALL have port fifo_dout  input  fifo_bit_len  FIFO Value_out.
REQ-014 SHALL have port level  output  4  shadow occupancy count, 0..fifo_size.
REQ-015 SHALL have ports full, empty  output  1 each  level==fifo_size, level==0 (decoded from level register).

Function
REQ-016 SHALL implement states IDLE, WR, RD, RD_CAP; all outputs registered.
REQ-017 SHALL never drive fifo_stage = 11.
REQ-018 SHALL treat write as eligible when wr_req=1 and level<fifo_size; read eligible when rd_req=1 and level>0.
REQ-019 In IDLE, only one eligible: SHALL grant it; both eligible: SHALL grant opposite of last_grant (round-robin); none: stay IDLE, fifo_stage=00.
REQ-020 Write grant edge: state->WR, fifo_stage<=10, fifo_din<=wr_data, wr_ack<=1, level<=level+1, last_grant<=write.
REQ-021 WR (one cycle): next edge state->IDLE, fifo_stage<=00, wr_ack<=0; write occupies 2 cycles.
REQ-022 Read grant edge: state->RD, fifo_stage<=01, level<=level-1, last_grant<=read.
REQ-023 RD: next edge state->RD_CAP, fifo_stage<=00.
REQ-024 RD_CAP: next edge rd_data<=fifo_dout, rd_ack<=1, state->IDLE; rd_ack cleared the following edge; rd_data holds until next read.
REQ-025 Read latency: 3 edges from grant edge to rd_ack visible; requests are not re-sampled in WR/RD/RD_CAP.
REQ-026 wr_req while full, or rd_req while empty, SHALL wait without ack, level unchanged, until eligible.
REQ-027 Requester still high in the cycle after its ack SHALL be treated as a new request in IDLE.
REQ-028 level SHALL never exceed fifo_size nor go below 0.
REQ-029 fifo_din SHALL hold its last value outside WR.

Reset
REQ-030 nreset=1 at an edge SHALL force: state IDLE, fifo_stage 00, fifo_din 0, rd_data 0, wr_ack 0, rd_ack 0, level 0, last_grant=read (write wins first tie); overrides any in-flight WR/RD/RD_CAP, no ack produced for aborted op.

Verification
REQ-031 Reset, then wr_req with wr_data=0xA5 -> fifo_stage 10 one cycle with fifo_din 0xA5, wr_ack one pulse, level 1, empty 0.
REQ-032 Continue with rd_req -> fifo_stage 01 one cycle, then 00; rd_ack with rd_data 0xA5 on 3rd edge after grant; level 0, empty 1.
REQ-033 Six writes 0x01..0x06 then seventh wr_req held -> full 1, level 6, no wr_ack; after one read (rd_data 0x01) the pending write is accepted, level 6.
REQ-034 rd_req on empty held 5 cycles -> no rd_ack, fifo_stage stays 00; then wr 0x3C -> write granted, then read returns 0x3C.
REQ-035 level 3, wr_req and rd_req held continuously -> grants alternate W,R,W,R starting with the side not last granted; level alternates 4,3; fifo_stage never 11.
REQ-036 nreset pulsed during RD -> no rd_ack, level 0, fifo_stage 00, empty 1 next cycle.
